// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit controller.
//   - funct3 encodings for the supported loads/stores
//   - FSM state encoding
//   - default bus timeout (used only when LSU_TIMEOUT_EN is defined)
//   - is_supported(): legal funct3 check per access direction
package lsu_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  localparam int unsigned TimeoutDefault = 255;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBus  = 2'b01,
    StResp = 2'b10
  } lsu_state_e;

  function automatic logic is_supported(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3Sb) || (f3 == F3Sh) || (f3 == F3Sw);
    end
    return (f3 == F3Lb) || (f3 == F3Lh) || (f3 == F3Lw) || (f3 == F3Lbu) || (f3 == F3Lhu);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational LSU formatting.
// Ports:
//   we_i, funct3_i, addr_lo_i : access kind and byte offset within the word
//   st_data_i                 : raw store data (rs2)
//   ld_raw_i                  : raw 32-bit word read from the bus
//   supported_o               : funct3 is legal for this direction
//   misaligned_o              : legal access that is not naturally aligned
//   sel_o                     : Wishbone byte lanes
//   st_data_o                 : store data replicated across all lanes
//   ld_data_o                 : extracted and sign/zero-extended load data
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_raw_i,
  output logic        supported_o,
  output logic        misaligned_o,
  output logic [3:0]  sel_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic        w_byte;
  logic        w_half;
  logic        w_word;
  logic [7:0]  w_byte_val;
  logic [15:0] w_half_val;

  always_comb begin
    supported_o  = is_supported(we_i, funct3_i);
    w_byte       = (funct3_i[1:0] == 2'b00);
    w_half       = (funct3_i[1:0] == 2'b01);
    w_word       = (funct3_i[1:0] == 2'b10);
    // Unsupported encodings never raise a misalignment flag.
    misaligned_o = supported_o &
                   ((w_half & addr_lo_i[0]) | (w_word & (addr_lo_i != 2'b00)));

    sel_o     = 4'b0000;
    st_data_o = st_data_i;
    if (w_byte) begin
      sel_o     = 4'b0001 << addr_lo_i;
      st_data_o = {4{st_data_i[7:0]}};
    end else if (w_half) begin
      sel_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      st_data_o = {2{st_data_i[15:0]}};
    end else if (w_word) begin
      sel_o     = 4'b1111;
    end

    unique case (addr_lo_i)
      2'b00:   w_byte_val = ld_raw_i[7:0];
      2'b01:   w_byte_val = ld_raw_i[15:8];
      2'b10:   w_byte_val = ld_raw_i[23:16];
      default: w_byte_val = ld_raw_i[31:24];
    endcase
    w_half_val = addr_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];

    unique case (funct3_i)
      F3Lb:    ld_data_o = {{24{w_byte_val[7]}}, w_byte_val};
      F3Lbu:   ld_data_o = {24'h0, w_byte_val};
      F3Lh:    ld_data_o = {{16{w_half_val[15]}}, w_half_val};
      F3Lhu:   ld_data_o = {16'h0, w_half_val};
      default: ld_data_o = ld_raw_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller; sole master on the Wishbone data port.
// Takes one request at a time (IDLE -> BUS -> RESP), checks alignment, runs a
// single classic Wishbone cycle and returns a one-cycle response with flags.
// Ports:
//   clk_i, rst_i                      : clock, async active-high reset
//   req_*                             : pipeline request (valid/ready handshake)
//   rsp_valid_o, rsp_data_o, e_*_o    : one-cycle response and exception flags
//   wbm_*                             : Wishbone classic master
// Configuration:
//   LSU_TIMEOUT_EN : when defined, a BUS access that sees no ack/err within
//                    TIMEOUT_CYCLES cycles is terminated with an access fault.
// All outputs come straight from registers.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_ld_acc_fault_o,
  output logic        e_st_acc_fault_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  lsu_state_e  r_state;
  logic        r_req_ready;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        r_cyc;
  logic        r_wbm_we;
  logic [31:0] r_adr;
  logic [3:0]  r_sel;
  logic [31:0] r_dat;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_ld_mis;
  logic        r_st_mis;
  logic        r_ld_acc;
  logic        r_st_acc;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] r_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  logic        w_in_idle;
  logic        w_we;
  logic [2:0]  w_funct3;
  logic [1:0]  w_addr_lo;
  logic        w_supported;
  logic        w_misaligned;
  logic [3:0]  w_sel;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_data;

  // In IDLE the formatter decodes the incoming request; afterwards it sees the
  // latched request so load data can be formatted when the ack arrives.
  assign w_in_idle = (r_state == StIdle);
  assign w_we      = w_in_idle ? req_we_i          : r_we;
  assign w_funct3  = w_in_idle ? req_funct3_i      : r_funct3;
  assign w_addr_lo = w_in_idle ? req_addr_i[1:0]   : r_addr_lo;

  lsu_align u_align (
    .we_i         (w_we),
    .funct3_i     (w_funct3),
    .addr_lo_i    (w_addr_lo),
    .st_data_i    (req_data_i),
    .ld_raw_i     (wbm_dat_i),
    .supported_o  (w_supported),
    .misaligned_o (w_misaligned),
    .sel_o        (w_sel),
    .st_data_o    (w_st_data),
    .ld_data_o    (w_ld_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_req_ready <= 1'b1;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_cyc       <= 1'b0;
      r_wbm_we    <= 1'b0;
      r_adr       <= '0;
      r_sel       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_ld_mis    <= 1'b0;
      r_st_mis    <= 1'b0;
      r_ld_acc    <= 1'b0;
      r_st_acc    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      // Response fields are single-cycle; they fall back to zero by default.
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_ld_mis    <= 1'b0;
      r_st_mis    <= 1'b0;
      r_ld_acc    <= 1'b0;
      r_st_acc    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req_valid_i) begin
            r_we        <= req_we_i;
            r_funct3    <= req_funct3_i;
            r_addr_lo   <= req_addr_i[1:0];
            r_req_ready <= 1'b0;
            if (!w_supported) begin
              r_state     <= StResp;
              r_rsp_valid <= 1'b1;
            end else if (w_misaligned) begin
              r_state     <= StResp;
              r_rsp_valid <= 1'b1;
              r_ld_mis    <= ~req_we_i;
              r_st_mis    <= req_we_i;
            end else begin
              r_state  <= StBus;
              r_cyc    <= 1'b1;
              r_wbm_we <= req_we_i;
              r_adr    <= {req_addr_i[31:2], 2'b00};
              r_sel    <= w_sel;
              r_dat    <= w_st_data;
`ifdef LSU_TIMEOUT_EN
              r_cnt    <= '0;
`endif
            end
          end
        end
        StBus: begin
          // err has priority over a simultaneous ack.
          if (wbm_err_i) begin
            r_state     <= StResp;
            r_cyc       <= 1'b0;
            r_wbm_we    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_ld_acc    <= ~r_we;
            r_st_acc    <= r_we;
          end else if (wbm_ack_i) begin
            r_state     <= StResp;
            r_cyc       <= 1'b0;
            r_wbm_we    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_we ? 32'h0 : w_ld_data;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= StResp;
            r_cyc       <= 1'b0;
            r_wbm_we    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_ld_acc    <= ~r_we;
            r_st_acc    <= r_we;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
`endif
        end
        StResp: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
          r_cyc       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o      = r_req_ready;
  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_data_o       = r_rsp_data;
  assign e_ld_addr_mis_o  = r_ld_mis;
  assign e_st_addr_mis_o  = r_st_mis;
  assign e_ld_acc_fault_o = r_ld_acc;
  assign e_st_acc_fault_o = r_st_acc;
  assign wbm_adr_o        = r_adr;
  assign wbm_dat_o        = r_dat;
  assign wbm_sel_o        = r_sel;
  assign wbm_we_o         = r_wbm_we;
  assign wbm_cyc_o        = r_cyc;
  assign wbm_stb_o        = r_cyc;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed requests, a request-level reference model and a
// per-cycle compare process on the negative clock edge.
module tb_lsu_ctrl;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_data_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_acc_fault_o, e_st_acc_fault_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;

  always #5 clk_i = ~clk_i;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_we_i         (req_we_i),
    .req_funct3_i     (req_funct3_i),
    .req_addr_i       (req_addr_i),
    .req_data_i       (req_data_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_data_o       (rsp_data_o),
    .e_ld_addr_mis_o  (e_ld_addr_mis_o),
    .e_st_addr_mis_o  (e_st_addr_mis_o),
    .e_ld_acc_fault_o (e_ld_acc_fault_o),
    .e_st_acc_fault_o (e_st_acc_fault_o),
    .wbm_adr_o        (wbm_adr_o),
    .wbm_dat_o        (wbm_dat_o),
    .wbm_sel_o        (wbm_sel_o),
    .wbm_we_o         (wbm_we_o),
    .wbm_cyc_o        (wbm_cyc_o),
    .wbm_stb_o        (wbm_stb_o),
    .wbm_dat_i        (wbm_dat_i),
    .wbm_ack_i        (wbm_ack_i),
    .wbm_err_i        (wbm_err_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Request-level reference: what the access must look like on the bus and
  // what a successful load returns, from size/offset arithmetic.
  typedef struct {
    bit          sup;
    bit          mis;
    bit          bus;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] ld;
  } exp_t;

  function automatic exp_t model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] d, input logic [31:0] rdat);
    exp_t   m;
    int     size;
    int     off;
    bit     sgn;
    longint v;
    m.sup = 0; m.mis = 0; m.bus = 0; m.sel = 0; m.wdat = 0; m.ld = 0;
    size = 0;
    sgn  = 0;
    if (we) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
    off   = int'(addr % 4);
    m.sup = (size != 0);
    if (m.sup) begin
      m.mis = (off % size) != 0;
      m.bus = !m.mis;
      m.sel = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) m.wdat[8*i +: 8] = d[8*(i % size) +: 8];
      v = (longint'(rdat) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
      if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
      m.ld = v[31:0];
    end
    return m;
  endfunction

  // Per-cycle expectations, maintained by the driver.
  bit          chk_en = 0;
  logic        exp_ready, exp_cyc, exp_we, exp_rv;
  logic        exp_lmis, exp_smis, exp_lacc, exp_sacc;
  logic [31:0] exp_adr, exp_dat, exp_rd;
  logic [3:0]  exp_sel;
  int          cur_rel;
  int          seen_cyc;
  logic [31:0] seen_data;
  logic [3:0]  seen_sel;
  logic [31:0] seen_wdat;
  bit          seen_bus;

  task automatic set_quiet(input logic ready);
    exp_ready = ready; exp_cyc = 0; exp_we = 0; exp_adr = 0; exp_sel = 0; exp_dat = 0;
    exp_rv = 0; exp_rd = 0; exp_lmis = 0; exp_smis = 0; exp_lacc = 0; exp_sacc = 0;
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("req_ready", {31'h0, req_ready_o}, {31'h0, exp_ready});
      chk("wbm_cyc", {31'h0, wbm_cyc_o}, {31'h0, exp_cyc});
      chk("wbm_stb", {31'h0, wbm_stb_o}, {31'h0, exp_cyc});
      if (exp_cyc) begin
        chk("wbm_we", {31'h0, wbm_we_o}, {31'h0, exp_we});
        chk("wbm_adr", wbm_adr_o, exp_adr);
        chk("wbm_sel", {28'h0, wbm_sel_o}, {28'h0, exp_sel});
        if (exp_we) chk("wbm_dat", wbm_dat_o, exp_dat);
      end
      chk("rsp_valid", {31'h0, rsp_valid_o}, {31'h0, exp_rv});
      chk("rsp_data", rsp_data_o, exp_rd);
      chk("flags", {28'h0, e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_acc_fault_o, e_st_acc_fault_o},
          {28'h0, exp_lmis, exp_smis, exp_lacc, exp_sacc});
      if (rsp_valid_o) begin
        seen_cyc  = cur_rel;
        seen_data = rsp_data_o;
      end
      if (wbm_cyc_o) begin
        seen_bus  = 1;
        seen_sel  = wbm_sel_o;
        seen_wdat = wbm_dat_o;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    cur_rel++;
  endtask

  // kind: 0 = ack, 1 = err, 2 = ack and err together.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] d, input int ws, input int kind,
                        input logic [31:0] rdat);
    exp_t m;
    bit   tmo;
    int   nbus;
    m = model(we, f3, addr, d, rdat);
    seen_cyc = -1; seen_bus = 0; seen_data = 32'hx; cur_rel = 0;
    req_valid_i = 1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_data_i = d;
    set_quiet(1);
    step();
    req_valid_i = 0;
    if (!m.bus) begin
      set_quiet(0);
      exp_rv = 1;
      exp_lmis = m.mis & !we;
      exp_smis = m.mis & we;
      step();
    end else begin
      tmo  = (TO != 0) && (ws >= TO);
      nbus = tmo ? TO : ws + 1;
      for (int k = 1; k <= nbus; k++) begin
        set_quiet(0);
        exp_cyc = 1; exp_we = we; exp_adr = {addr[31:2], 2'b00}; exp_sel = m.sel;
        exp_dat = m.wdat;
        if (!tmo && k == nbus) begin
          wbm_ack_i = (kind != 1);
          wbm_err_i = (kind != 0);
          wbm_dat_i = rdat;
        end
        step();
        wbm_ack_i = 0; wbm_err_i = 0; wbm_dat_i = 32'h5A5A_5A5A;
      end
      set_quiet(0);
      exp_rv = 1;
      if (tmo || kind != 0) begin
        exp_lacc = !we;
        exp_sacc = we;
      end else if (!we) begin
        exp_rd = m.ld;
      end
      step();
    end
    set_quiet(1);
  endtask

  exp_t pm;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; req_valid_i = 0; req_we_i = 0; req_funct3_i = 0; req_addr_i = 0;
    req_data_i = 0; wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
    set_quiet(1);
    repeat (2) @(posedge clk_i);
    #1;
    // Reset state: everything 0 except req_ready_o.
    chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, 25'h0}, 32'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_dat", wbm_dat_o, 32'h0);
    chk("rst_rsp", {rsp_valid_o, e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_acc_fault_o,
                    e_st_acc_fault_o, 27'h0}, 32'h0);
    chk("rst_rdata", rsp_data_o, 32'h0);
    rst_i = 0;
    chk_en = 1;

    // Pin the model with hand-computed values.
    pm = model(0, 3'b000, 32'h103, 0, 32'h80FF_0000);
    chk("model_lb", pm.ld, 32'hFFFF_FF80);
    pm = model(0, 3'b100, 32'h103, 0, 32'h80FF_0000);
    chk("model_lbu", pm.ld, 32'h0000_0080);
    pm = model(1, 3'b001, 32'h202, 32'h1234_ABCD, 0);
    chk("model_sh", {pm.sel, pm.wdat[31:4]}, {4'b1100, 28'hABCD_ABC});
    pm = model(0, 3'b010, 32'h101, 0, 0);
    chk("model_mis", {31'h0, pm.mis}, 32'h1);

    step();

    // LW with two wait states.
    do_req(0, 3'b010, 32'h100, 32'h0, 2, 0, 32'hDEAD_BEEF);
    chk("lw_latency", seen_cyc, 4);
    chk("lw_data", seen_data, 32'hDEAD_BEEF);
    chk("lw_sel", {28'h0, seen_sel}, 32'hF);

    do_req(0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
    chk("lb_data", seen_data, 32'hFFFF_FF80);
    chk("lb_sel", {28'h0, seen_sel}, 32'h8);
    do_req(0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
    chk("lbu_data", seen_data, 32'h0000_0080);

    do_req(1, 3'b001, 32'h202, 32'h1234_ABCD, 1, 0, 32'hFFFF_FFFF);
    chk("sh_wdat", seen_wdat, 32'hABCD_ABCD);
    chk("sh_rdata", seen_data, 32'h0);

    do_req(0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h8001_7FFF);
    do_req(0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h8001_7FFF);
    do_req(0, 3'b001, 32'h100, 32'h0, 0, 0, 32'h8001_7FFF);
    do_req(1, 3'b000, 32'h301, 32'h0000_00A5, 0, 0, 32'h0);
    do_req(1, 3'b010, 32'h304, 32'h0102_0304, 3, 0, 32'h0);

    // Misaligned: no bus cycle, response in cycle 1.
    do_req(0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
    chk("lw_mis_lat", seen_cyc, 1);
    chk("lw_mis_nobus", {31'h0, seen_bus}, 32'h0);
    do_req(1, 3'b001, 32'h3, 32'h0, 0, 0, 32'h0);
    chk("sh_mis_nobus", {31'h0, seen_bus}, 32'h0);

    // Unsupported encodings.
    do_req(0, 3'b011, 32'h101, 32'h0, 0, 0, 32'h0);
    do_req(1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0);

    // Bus errors; err wins over a simultaneous ack.
    do_req(0, 3'b010, 32'h400, 32'h0, 1, 1, 32'h1111_1111);
    do_req(1, 3'b010, 32'h404, 32'hCAFE_F00D, 0, 2, 32'h2222_2222);

    // Long wait (times out when the timeout feature is built in).
    do_req(0, 3'b010, 32'h500, 32'h0, 20, 0, 32'h7654_3210);

    // ack/err while idle are ignored.
    wbm_ack_i = 1; wbm_err_i = 1;
    step(); step();
    wbm_ack_i = 0; wbm_err_i = 0;
    step();

    // Reset in the middle of a bus cycle.
    req_valid_i = 1; req_we_i = 1; req_funct3_i = 3'b010; req_addr_i = 32'h600;
    req_data_i = 32'h0BAD_CAFE;
    set_quiet(1);
    step();
    req_valid_i = 0;
    set_quiet(0);
    exp_cyc = 1; exp_we = 1; exp_adr = 32'h600; exp_sel = 4'hF; exp_dat = 32'h0BAD_CAFE;
    @(negedge clk_i);
    #1;
    set_quiet(1);
    rst_i = 1;
    #1;
    chk("rst_mid_cyc", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready_o}, 32'h1);
    seen_cyc = -1;
    step();
    rst_i = 0;
    step(); step(); step();
    chk("rst_mid_norsp", seen_cyc, -1);

    // Back-to-back after reset still works.
    do_req(0, 3'b000, 32'h700, 32'h0, 0, 0, 32'h0000_0042);
    chk("post_rst_lb", seen_data, 32'h0000_0042);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
